// File: rtl/chunk_row_burst_pkg.sv
// ---------------------------------------------------------------------------
// chunk_row_burst_pkg
//   Shared definitions for the chunk row burst generator.
//   - TAU_VSIZE / TAU_GLOBAL_ADDR_BW mirror the TauCfg project configuration
//     (elements per DRAM burst, global element address width). They are the
//     only source of the block's default geometry.
//   - state_t is the row/burst FSM encoding, also exported on dbg_state.
//   Optional feature macro used by the top: CHUNK_ROW_BURST_SKIP_INVALID_EN.
// ---------------------------------------------------------------------------
package chunk_row_burst_pkg;

    localparam int unsigned TAU_VSIZE          = 32;
    localparam int unsigned TAU_GLOBAL_ADDR_BW = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/chunk_row_burst_calc.sv
// ---------------------------------------------------------------------------
// chunk_row_burst_calc  (RowBurstCalc)
//   Purely combinational row geometry: the VSIZE-aligned address of the first
//   burst of a row and the number of VSIZE bursts needed to cover it.
//   Ports:
//     linear  in  GBW  row start element address
//     len     in  GBW  row length in elements
//     aligned out GBW  linear with the low V_BW bits cleared
//     n       out GBW  ceil(((linear mod VSIZE) + len) / VSIZE), 1 when len==0
// ---------------------------------------------------------------------------
module chunk_row_burst_calc
    import chunk_row_burst_pkg::*;
#(
    parameter int unsigned VSIZE = TAU_VSIZE,
    parameter int unsigned GBW   = TAU_GLOBAL_ADDR_BW,
    parameter int unsigned V_BW  = $clog2(VSIZE)
) (
    input  logic [GBW-1:0] linear,
    input  logic [GBW-1:0] len,
    output logic [GBW-1:0] aligned,
    output logic [GBW-1:0] n
);

    // One extra bit so offset + len + (VSIZE-1) cannot overflow before the
    // divide; the quotient always fits back into GBW bits.
    logic [GBW:0] span;
    logic [GBW:0] rounded;

    always_comb begin
        span    = {{(GBW + 1 - V_BW){1'b0}}, linear[V_BW-1:0]} + {1'b0, len};
        rounded = span + (GBW + 1)'(VSIZE - 1);
        aligned = {linear[GBW-1:V_BW], {V_BW{1'b0}}};
        // An empty row still produces one (fill) burst so the consumer sees
        // every row of the chunk, including the islast marker.
        if (len == '0) begin
            n = GBW'(1);
        end else begin
            n = GBW'(rounded >> V_BW);
        end
    end

endmodule

// File: rtl/chunk_row_burst.sv
// ---------------------------------------------------------------------------
// chunk_row_burst  (ChunkRowBurst)
//   Splits row commands into VSIZE-aligned DRAM read bursts.
//   Optional feature: define CHUNK_ROW_BURST_SKIP_INVALID_EN so that an
//   out-of-bounds row (i_row_valid=0) emits a single fill burst instead of
//   one fill burst per covered VSIZE block.
//
//   Handshake: both interfaces are valid/ready style. A row transfers on a
//   cycle where row_rdy (valid) and row_ack (ready) are both high; a burst
//   transfers where dramra_rdy (valid) and dramra_ack (ready) are both high.
//   While dramra_rdy is high the burst outputs hold until dramra_ack.
//
//   Ports:
//     i_clk, i_rst       clock, synchronous active-high reset
//     row_rdy / row_ack  row command valid / accepted
//     i_row_linear       row start element address
//     i_row_islast       row is the last of the chunk
//     i_row_pad          leading pad count for the first burst
//     i_row_valid        row in bounds (0 = all padding)
//     i_row_len          row length in elements
//     dramra_rdy / _ack  burst request valid / taken
//     o_dramra_addr      VSIZE-aligned burst address
//     o_dramra_pad       pad for this burst (first burst only)
//     o_dramra_fill      synthesize padding, no memory read
//     o_dramra_islast    final burst of the chunk
//     dbg_state          current FSM state (ST_IDLE / ST_BURST)
// ---------------------------------------------------------------------------
module chunk_row_burst
    import chunk_row_burst_pkg::*;
#(
    parameter int unsigned VSIZE = TAU_VSIZE,
    parameter int unsigned GBW   = TAU_GLOBAL_ADDR_BW,
    parameter int unsigned V_BW  = $clog2(VSIZE)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            row_rdy,
    output logic            row_ack,
    input  logic [GBW-1:0]  i_row_linear,
    input  logic            i_row_islast,
    input  logic [V_BW-1:0] i_row_pad,
    input  logic            i_row_valid,
    input  logic [GBW-1:0]  i_row_len,
    output logic            dramra_rdy,
    input  logic            dramra_ack,
    output logic [GBW-1:0]  o_dramra_addr,
    output logic [V_BW-1:0] o_dramra_pad,
    output logic            o_dramra_fill,
    output logic            o_dramra_islast,
    output logic            dbg_state
);

    state_t state_q;
    state_t state_d;

    logic [GBW-1:0]  addr_q;
    logic [GBW-1:0]  remain_q;   // bursts left in the row, including current
    logic [V_BW-1:0] pad_q;
    logic            fill_q;
    logic            islast_q;
    logic            first_q;

    logic [GBW-1:0]  calc_aligned;
    logic [GBW-1:0]  calc_n;
    logic [GBW-1:0]  row_n;
    logic            final_burst;
    logic            load_row;
    logic            step;

    chunk_row_burst_calc #(
        .VSIZE (VSIZE),
        .GBW   (GBW),
        .V_BW  (V_BW)
    ) u_calc (
        .linear  (i_row_linear),
        .len     (i_row_len),
        .aligned (calc_aligned),
        .n       (calc_n)
    );

    // Burst count actually loaded for an incoming row.
    always_comb begin
        row_n = calc_n;
`ifdef CHUNK_ROW_BURST_SKIP_INVALID_EN
        if (!i_row_valid) begin
            row_n = GBW'(1);
        end
`endif
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        row_ack     = 1'b0;
        dramra_rdy  = 1'b0;
        load_row    = 1'b0;
        step        = 1'b0;
        final_burst = (remain_q == GBW'(1));

        case (state_q)
            ST_IDLE: begin
                row_ack = row_rdy;
                if (row_rdy) begin
                    load_row = 1'b1;
                    state_d  = ST_BURST;
                end
            end
            ST_BURST: begin
                dramra_rdy = 1'b1;
                if (dramra_ack) begin
                    if (final_burst) begin
                        // Taking the next row on the final ack keeps
                        // dramra_rdy high with no idle cycle between rows.
                        if (row_rdy) begin
                            row_ack  = 1'b1;
                            load_row = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Burst outputs are forced to zero outside BURST so nothing stale from a
    // finished row is presented.
    always_comb begin
        o_dramra_addr   = '0;
        o_dramra_pad    = '0;
        o_dramra_fill   = 1'b0;
        o_dramra_islast = 1'b0;
        if (state_q == ST_BURST) begin
            o_dramra_addr   = addr_q;
            o_dramra_pad    = first_q ? pad_q : '0;
            o_dramra_fill   = fill_q;
            o_dramra_islast = islast_q && final_burst;
        end
    end

    assign dbg_state = state_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            pad_q    <= '0;
            fill_q   <= 1'b0;
            islast_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_row) begin
                addr_q   <= calc_aligned;
                remain_q <= row_n;
                pad_q    <= i_row_pad;
                fill_q   <= !i_row_valid || (i_row_len == '0);
                islast_q <= i_row_islast;
                first_q  <= 1'b1;
            end else if (step) begin
                // Address wraps naturally modulo 2^GBW.
                addr_q   <= addr_q + GBW'(VSIZE);
                remain_q <= remain_q - GBW'(1);
                first_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chunk_row_burst.sv
module tb_chunk_row_burst;

    localparam int GBW  = 32;
    localparam int V_BW = 5;

    logic            clk;
    logic            rst;
    logic            row_rdy;
    logic            row_ack;
    logic [GBW-1:0]  row_linear;
    logic            row_islast;
    logic [V_BW-1:0] row_pad;
    logic            row_valid;
    logic [GBW-1:0]  row_len;
    logic            dramra_rdy;
    logic            dramra_ack;
    logic [GBW-1:0]  dramra_addr;
    logic [V_BW-1:0] dramra_pad;
    logic            dramra_fill;
    logic            dramra_islast;
    logic            dbg_state;

    chunk_row_burst dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .row_rdy         (row_rdy),
        .row_ack         (row_ack),
        .i_row_linear    (row_linear),
        .i_row_islast    (row_islast),
        .i_row_pad       (row_pad),
        .i_row_valid     (row_valid),
        .i_row_len       (row_len),
        .dramra_rdy      (dramra_rdy),
        .dramra_ack      (dramra_ack),
        .o_dramra_addr   (dramra_addr),
        .o_dramra_pad    (dramra_pad),
        .o_dramra_fill   (dramra_fill),
        .o_dramra_islast (dramra_islast),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] linear;
        logic [31:0] len;
        logic [4:0]  pad;
        logic        valid;
        logic        islast;
        int          exp_n;
        logic [31:0] exp_addr;
        logic        exp_fill;
    } vec_t;

    vec_t vecs[9];

    // Drive one row, then consume and check each of its bursts.
    task automatic run_row(input vec_t v);
        logic [31:0] ea;
        int w;
        row_linear = v.linear;
        row_len    = v.len;
        row_pad    = v.pad;
        row_valid  = v.valid;
        row_islast = v.islast;
        row_rdy    = 1'b1;
        #1;
        check("row_ack_idle", row_ack, 1);
        tick();
        row_rdy = 1'b0;
        // Inputs change after acceptance; the row in flight must not care.
        row_linear = 32'hDEAD_BEEF;
        row_len    = 32'h0000_1000;
        row_pad    = 5'd17;
        row_valid  = ~v.valid;
        row_islast = ~v.islast;
        for (int k = 0; k < v.exp_n; k++) begin
            w = 0;
            while (!dramra_rdy && w < 20) begin
                tick();
                w++;
            end
            ea = v.exp_addr + 32'(k * 32);
            check("burst_rdy", dramra_rdy, 1);
            check("burst_addr", dramra_addr, ea);
            check("burst_pad", dramra_pad, (k == 0) ? v.pad : 5'd0);
            check("burst_fill", dramra_fill, v.exp_fill);
            check("burst_islast", dramra_islast, v.islast && (k == v.exp_n - 1));
            check("row_ack_busy", row_ack, 0);
            dramra_ack = 1'b1;
            tick();
            dramra_ack = 1'b0;
        end
        check("rdy_after_row", dramra_rdy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        row_rdy    = 1'b0;
        row_linear = '0;
        row_islast = 1'b0;
        row_pad    = '0;
        row_valid  = 1'b0;
        row_len    = '0;
        dramra_ack = 1'b0;

        //            linear        len  pad valid last  n  first addr   fill
        vecs[0] = '{32'h0000_0040, 32'd32, 5'd0, 1'b1, 1'b1, 1, 32'h0000_0040, 1'b0};
        vecs[1] = '{32'h0000_0045, 32'd40, 5'd3, 1'b1, 1'b1, 2, 32'h0000_0040, 1'b0};
        vecs[2] = '{32'h0000_0045, 32'd40, 5'd3, 1'b1, 1'b0, 2, 32'h0000_0040, 1'b0};
`ifdef CHUNK_ROW_BURST_SKIP_INVALID_EN
        vecs[3] = '{32'h0000_0045, 32'd40, 5'd3, 1'b0, 1'b1, 1, 32'h0000_0040, 1'b1};
`else
        vecs[3] = '{32'h0000_0045, 32'd40, 5'd3, 1'b0, 1'b1, 2, 32'h0000_0040, 1'b1};
`endif
        vecs[4] = '{32'hFFFF_FFF0, 32'd48, 5'd0, 1'b1, 1'b1, 2, 32'hFFFF_FFE0, 1'b0};
        vecs[5] = '{32'h0000_0023, 32'd0,  5'd2, 1'b1, 1'b1, 1, 32'h0000_0020, 1'b1};
        vecs[6] = '{32'h0000_001F, 32'd1,  5'd7, 1'b1, 1'b0, 1, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'h0000_001F, 32'd2,  5'd9, 1'b1, 1'b1, 2, 32'h0000_0000, 1'b0};
        vecs[8] = '{32'h0000_0100, 32'd96, 5'd0, 1'b1, 1'b1, 3, 32'h0000_0100, 1'b0};

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_rdy", dramra_rdy, 0);
        check("rst_row_ack", row_ack, 0);
        check("rst_addr", dramra_addr, 0);
        check("rst_pad", dramra_pad, 0);
        check("rst_fill", dramra_fill, 0);
        check("rst_islast", dramra_islast, 0);
        check("rst_state", dbg_state, 0);

        // Table-driven rows
        for (int i = 0; i < 9; i++) begin
            run_row(vecs[i]);
            tick();
        end

        // Back-to-back rows with dramra_ack held high: no bubble.
        row_linear = 32'h0000_0045; row_len = 32'd40; row_pad = 5'd3;
        row_valid  = 1'b1; row_islast = 1'b0; row_rdy = 1'b1;
        tick();   // row 1 accepted from IDLE
        row_linear = 32'h0000_0040; row_len = 32'd32; row_pad = 5'd0;
        row_valid  = 1'b1; row_islast = 1'b1;
        dramra_ack = 1'b1;
        #1;
        check("b2b_rdy0", dramra_rdy, 1);
        check("b2b_addr0", dramra_addr, 32'h40);
        check("b2b_pad0", dramra_pad, 3);
        check("b2b_ack0", row_ack, 0);
        tick();
        check("b2b_rdy1", dramra_rdy, 1);
        check("b2b_addr1", dramra_addr, 32'h60);
        check("b2b_islast1", dramra_islast, 0);
        check("b2b_ack1", row_ack, 1);
        tick();   // row 2 accepted on final ack of row 1
        row_rdy = 1'b0;
        #1;
        check("b2b_rdy2", dramra_rdy, 1);
        check("b2b_addr2", dramra_addr, 32'h40);
        check("b2b_islast2", dramra_islast, 1);
        check("b2b_ack2", row_ack, 0);
        tick();
        dramra_ack = 1'b0;
        check("b2b_done", dramra_rdy, 0);
        tick();

        // Stall with dramra_ack low, then reset in the middle of the row.
        row_linear = 32'h0000_0104; row_len = 32'd88; row_pad = 5'd4;
        row_valid  = 1'b1; row_islast = 1'b1; row_rdy = 1'b1;
        tick();
        row_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            row_linear = 32'(c * 32'h1234_5678);
            check("stall_rdy", dramra_rdy, 1);
            check("stall_addr", dramra_addr, 32'h100);
            check("stall_pad", dramra_pad, 4);
            check("stall_islast", dramra_islast, 0);
            tick();
        end
        dramra_ack = 1'b1;
        tick();
        dramra_ack = 1'b0;
        check("mid_addr", dramra_addr, 32'h120);
        check("mid_pad", dramra_pad, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rdy", dramra_rdy, 0);
        check("rst_mid_addr", dramra_addr, 0);
        dramra_ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("rst_mid_quiet", dramra_rdy, 0);
            tick();
        end
        dramra_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chunk_row_burst.md
CHUNK_ROW_BURST -- requirements
Module: ChunkRowBurst

Interface
REQ-001 SHALL have parameters (none local): VSIZE from TauCfg::VSIZE (elements per burst, power of 2); GBW from TauCfg::GLOBAL_ADDR_BW (address width); V_BW = $clog2(VSIZE).
REQ-002 SHALL have ports; clock and reset are one clock, synchronous active-high reset:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- row_rdy  in  1  row command valid
- row_ack  out  1  row command accepted
- i_row_linear  in  GBW  row start element address
- i_row_islast  in  1  last row of chunk
- i_row_pad  in  V_BW  leading pad count
- i_row_valid  in  1  row in bounds (0 = all padding)
- i_row_len  in  GBW  row length in elements, static per chunk
- dramra_rdy  out  1  burst request valid
- dramra_ack  in  1  burst request taken
- o_dramra_addr  out  GBW  VSIZE-aligned burst address
- o_dramra_pad  out  V_BW  pad for this burst
- o_dramra_fill  out  1  1 = synthesize pad, no memory read
- o_dramra_islast  out  1  final burst of chunk

Function
REQ-003 SHALL be FSM with states IDLE, BURST.
REQ-004 In IDLE: row_ack = row_rdy; on row_ack, latch inputs and go BURST.
REQ-005 Burst count N = ceil(((i_row_linear mod VSIZE) + i_row_len) / VSIZE), in GBW-bit unsigned; i_row_len==0 gives N=1 with fill=1.
REQ-006 First burst address = i_row_linear with low V_BW bits cleared; each dramra_ack adds VSIZE, wraps modulo 2^GBW.
REQ-007 In BURST: dramra_rdy=1; outputs stable until dramra_ack.
REQ-008 o_dramra_pad = latched pad on first burst, 0 on later bursts.
REQ-009 o_dramra_fill = !latched valid (or len==0) on every burst of the row.
REQ-010 o_dramra_islast = latched islast AND final burst of the row.
REQ-011 On dramra_ack of final burst: if row_rdy, assert row_ack same cycle, latch new row, stay BURST (zero bubble); else go IDLE.
REQ-012 row_ack SHALL never assert in BURST except per REQ-011.
REQ-013 Latency: row accepted cycle t -> dramra_rdy high at t+1.
REQ-014 Inputs sampled only on row_ack; changes while BURST ignored.

Reset
REQ-015 On i_rst at posedge: state IDLE; dramra_rdy=0, row_ack combinational from state, all latched regs and outputs 0.
REQ-016 Reset mid-BURST SHALL drop remaining bursts; no request after reset until a new row_ack.

Configuration
REQ-017 Macro CHUNK_ROW_BURST_SKIP_INVALID_EN: defined -> row with i_row_valid=0 emits exactly one burst (fill=1, pad=latched pad, addr per REQ-006, islast=latched islast) regardless of N; undefined -> invalid rows emit N fill bursts per REQ-005.

Structure
REQ-018 SHALL take VSIZE/GBW only from TauCfg; no new package types.
REQ-019 SHALL use one combinational sub-module RowBurstCalc (inputs linear, len; outputs aligned address, N); FSM/counters in top.

Verification (VSIZE=32, GBW=32)
REQ-020 linear=0x40, len=32, valid=1, pad=0, islast=1 -> one burst addr=0x40, fill=0, islast=1.
REQ-021 linear=0x45, len=40, pad=3 -> 2 bursts addr 0x40 (pad=3), 0x60 (pad=0); islast only on 2nd if input islast=1.
REQ-022 valid=0, linear=0x45, len=40 -> without macro 2 bursts fill=1; with macro 1 burst fill=1.
REQ-023 Two rows back-to-back, dramra_ack always 1 -> row_ack for row 2 in same cycle as final ack of row 1, no idle cycle on dramra_rdy.
REQ-024 dramra_ack held 0 for 5 cycles -> outputs stable; then i_rst during 2nd of 3 bursts -> dramra_rdy=0 next cycle, no further bursts.
REQ-025 linear=0xFFFFFFF0, len=48 -> bursts 0xFFFFFFE0, 0x00000000 (wrap).
